shiftreg_sipo: RTL and testbench



---
 rtl/shiftreg_sipo.sv | 87 ++++++++
 tb/tb_shiftreg_sipo.sv | 173 +++++++++++++++++
 2 files changed

// File: rtl/shiftreg_sipo.sv
// Serial-in, parallel-out receiver: rebuilds MSB-first serial words and offers each
// completed word on a single-entry valid/ready output with sticky error flags.
module shiftreg_sipo #(
    parameter int WIDTH = 16
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             sin,
    input  logic             sin_valid,
    input  logic             sync,
    output logic [WIDTH-1:0] dout,
    output logic             dout_valid,
    input  logic             dout_ready,
    output logic             busy,
    output logic             overflow,
    output logic             frame_err
);
    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);
    localparam logic [CW-1:0] ONE  = CW'(1);

    logic [WIDTH-1:0] r_sh;
    logic [CW-1:0]    r_cnt;
    logic [WIDTH-1:0] r_dout;
    logic             r_dout_valid;
    logic             r_busy;
    logic             r_overflow;
    logic             r_frame_err;

    logic [WIDTH-1:0] w_word;
    logic             w_complete;
    logic             w_accept;

    assign w_word     = {r_sh[WIDTH-2:0], sin};
    // A sync bit always starts a fresh word, so it can never complete one.
    assign w_complete = sin_valid && !sync && (r_cnt == LAST);
    assign w_accept   = !r_dout_valid || dout_ready;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_sh         <= '0;
            r_cnt        <= '0;
            r_dout       <= '0;
            r_dout_valid <= 1'b0;
            r_busy       <= 1'b0;
            r_overflow   <= 1'b0;
            r_frame_err  <= 1'b0;
        end else begin
            if (sin_valid) begin
                if (sync) begin
                    r_sh   <= {{(WIDTH-1){1'b0}}, sin};
                    r_cnt  <= ONE;
                    r_busy <= 1'b1;
                    if (r_cnt != '0) begin
                        r_frame_err <= 1'b1;
                    end
                end else if (w_complete) begin
                    r_sh   <= w_word;
                    r_cnt  <= '0;
                    r_busy <= 1'b0;
                end else begin
                    r_sh   <= w_word;
                    r_cnt  <= r_cnt + ONE;
                    r_busy <= 1'b1;
                end
            end

            // Output stage: a completion either refills the holding register or is lost.
            if (w_complete) begin
                if (w_accept) begin
                    r_dout       <= w_word;
                    r_dout_valid <= 1'b1;
                end else begin
                    r_overflow <= 1'b1;
                end
            end else if (r_dout_valid && dout_ready) begin
                r_dout_valid <= 1'b0;
            end
        end
    end

    assign dout       = r_dout;
    assign dout_valid = r_dout_valid;
    assign busy       = r_busy;
    assign overflow   = r_overflow;
    assign frame_err  = r_frame_err;
endmodule

// File: tb/tb_shiftreg_sipo.sv
// Randomized bench for shiftreg_sipo, checked every cycle against a word-level model.
module tb_shiftreg_sipo;
    localparam int W = 16;

    logic         clk = 1'b0;
    logic         rst = 1'b0;
    logic         sin = 1'b0;
    logic         sin_valid = 1'b0;
    logic         sync = 1'b0;
    logic         dout_ready = 1'b0;
    logic [W-1:0] dout;
    logic         dout_valid;
    logic         busy;
    logic         overflow;
    logic         frame_err;

    int n_checks = 0;
    int n_pass   = 0;

    // Model state: bits received so far in the current word and their value.
    int          m_nbits = 0;
    int unsigned m_acc   = 0;
    int unsigned m_dout  = 0;
    bit          m_valid = 0;
    bit          m_ovf   = 0;
    bit          m_ferr  = 0;

    shiftreg_sipo #(.WIDTH(W)) dut (
        .clk        (clk),
        .rst        (rst),
        .sin        (sin),
        .sin_valid  (sin_valid),
        .sync       (sync),
        .dout       (dout),
        .dout_valid (dout_valid),
        .dout_ready (dout_ready),
        .busy       (busy),
        .overflow   (overflow),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, obs, exp, $time);
    endtask

    // Apply one set of inputs for one clock edge, advance the model, compare all outputs.
    task automatic step(input bit b, input bit v, input bit s, input bit r, input bit rs);
        bit          complete;
        int unsigned word;
        @(negedge clk);
        sin = b; sin_valid = v; sync = s; dout_ready = r; rst = rs;
        @(posedge clk);
        #1;
        if (rs) begin
            m_nbits = 0; m_acc = 0; m_dout = 0; m_valid = 0; m_ovf = 0; m_ferr = 0;
        end else begin
            complete = v && !s && (m_nbits == W - 1);
            word     = (m_acc * 2 + b) % (1 << W);
            if (complete) begin
                if (!m_valid || r) begin m_dout = word; m_valid = 1; end
                else m_ovf = 1;
            end else if (m_valid && r) begin
                m_valid = 0;
            end
            if (v) begin
                if (s) begin
                    if (m_nbits != 0) m_ferr = 1;
                    m_acc = b; m_nbits = 1;
                end else if (complete) begin
                    m_acc = 0; m_nbits = 0;
                end else begin
                    m_acc = word; m_nbits++;
                end
            end
        end
        check("dout", 32'(dout), m_dout);
        check("dout_valid", 32'(dout_valid), 32'(m_valid));
        check("busy", 32'(busy), 32'(m_nbits != 0));
        check("overflow", 32'(overflow), 32'(m_ovf));
        check("frame_err", 32'(frame_err), 32'(m_ferr));
    endtask

    task automatic do_reset();
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b1);
    endtask

    // Send one word MSB-first. maxgap inserts idle cycles (with random sync noise);
    // last_only drives ready solely on the LSB edge.
    task automatic send_word(input logic [W-1:0] w, input bit use_sync, input int maxgap,
                             input bit rdy, input bit last_only);
        bit r;
        for (int i = W - 1; i >= 0; i--) begin
            r = last_only ? 1'b0 : rdy;
            if (maxgap > 0) begin
                repeat ($urandom_range(0, maxgap))
                    step(1'($urandom), 1'b0, 1'($urandom), r, 1'b0);
            end
            if (last_only && i == 0) r = 1'b1;
            step(w[i], 1'b1, use_sync && (i == W - 1), r, 1'b0);
        end
    endtask

    initial begin
        // 1: contiguous synced word
        do_reset();
        check("reset_dout", 32'(dout), 32'h0);
        send_word(16'hA5C3, 1'b1, 0, 1'b1, 1'b0);
        check("t1_word", 32'(dout), 32'hA5C3);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        check("t1_valid_drop", 32'(dout_valid), 32'h0);
        $display("test1 A5C3 contiguous: dout=0x%0h", dout);

        // 2: same word with idle gaps and ignored sync
        do_reset();
        send_word(16'hA5C3, 1'b1, 3, 1'b1, 1'b0);
        check("t2_word", 32'(dout), 32'hA5C3);
        $display("test2 A5C3 gapped: dout=0x%0h", dout);

        // 3: back-pressure causes overflow
        do_reset();
        send_word(16'h1234, 1'b0, 0, 1'b0, 1'b0);
        send_word(16'hFFFF, 1'b0, 0, 1'b0, 1'b0);
        check("t3_held", 32'(dout), 32'h1234);
        check("t3_ovf", 32'(overflow), 32'h1);
        step(1'b0, 1'b0, 1'b0, 1'b1, 1'b0);
        step(1'b0, 1'b0, 1'b0, 1'b0, 1'b0);
        $display("test3 overflow: dout=0x%0h ovf=%0b", dout, overflow);

        // 4: ready only on the completing edge replaces the held word
        do_reset();
        send_word(16'h1234, 1'b0, 0, 1'b0, 1'b0);
        send_word(16'hBEEF, 1'b0, 0, 1'b0, 1'b1);
        check("t4_word", 32'(dout), 32'hBEEF);
        check("t4_ovf", 32'(overflow), 32'h0);
        $display("test4 same-edge refill: dout=0x%0h", dout);

        // 5: garbage then sync
        do_reset();
        repeat (5) step(1'($urandom), 1'b1, 1'b0, 1'b1, 1'b0);
        send_word(16'h0F0F, 1'b1, 0, 1'b1, 1'b0);
        check("t5_ferr", 32'(frame_err), 32'h1);
        check("t5_word", 32'(dout), 32'h0F0F);
        send_word(16'h8001, 1'b0, 1, 1'b1, 1'b0);
        check("t5_next", 32'(dout), 32'h8001);
        $display("test5 framing: dout=0x%0h ferr=%0b", dout, frame_err);

        // 6: reset mid-word
        do_reset();
        send_word(16'h1111, 1'b0, 0, 1'b0, 1'b0);
        for (int i = W - 1; i >= W - 8; i--) step(1'(16'hC0DE >> i), 1'b1, 1'b0, 1'b0, 1'b0);
        do_reset();
        check("t6_busy", 32'(busy), 32'h0);
        check("t6_valid", 32'(dout_valid), 32'h0);
        send_word(16'h5A5A, 1'b0, 0, 1'b1, 1'b0);
        check("t6_word", 32'(dout), 32'h5A5A);
        $display("test6 mid-word reset: dout=0x%0h", dout);

        // 7: random stress
        do_reset();
        for (int i = 0; i < 3000; i++) begin
            step(1'($urandom), ($urandom_range(0, 3) != 0), ($urandom_range(0, 40) == 0),
                 ($urandom_range(0, 3) != 0), ($urandom_range(0, 500) == 0));
        end
        $display("test7 random stress done");

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end
endmodule
